spi_cmd_ctrl: RTL and testbench

- SPI-slave command controller between the host SPI link and the measurement front end.
- Decodes 2-byte frames (command byte, argument byte) to drive the analogue selects (input/MU/AVK/filters) and the device chip-selects (comp1/comp2/relay).
- Serves counter read-back (count_p/count_m snapshot) on MISO.
- All logic runs on clk_12mhz; the SPI pins are asynchronous and oversampled.

---
 rtl/spi_cmd_pkg.sv | 46 ++++
 rtl/spi_slave_frontend.sv | 97 +++++++++
 rtl/spi_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, SET_SEL field ids, FSM encodings and frame classification
// for the SPI command controller.
package spi_cmd_pkg;

  localparam logic [7:0] OP_SET_SEL  = 8'h01;
  localparam logic [7:0] OP_NOP      = 8'h02;
  localparam logic [7:0] OP_DEV_SEL  = 8'h03;
  localparam logic [7:0] OP_ALL_OFF  = 8'h04;
  localparam logic [7:0] OP_READ_CNT = 8'h05;

  localparam logic [3:0] FLD_INPUT = 4'd1;
  localparam logic [3:0] FLD_MU    = 4'd2;
  localparam logic [3:0] FLD_AVK   = 4'd3;
  localparam logic [3:0] FLD_FIL1  = 4'd4;
  localparam logic [3:0] FLD_FIL2  = 4'd5;

  localparam logic [7:0] DEV_COMP1 = 8'h01;
  localparam logic [7:0] DEV_COMP2 = 8'h02;
  localparam logic [7:0] DEV_RELAY = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG,
    ST_WAIT,
    ST_TX,
    ST_EXEC
  } state_e;

  typedef enum logic [1:0] {
    EX_NONE,
    EX_ERR,
    EX_RUN
  } exec_e;

  // What EXEC must do, judged from where the frame stood when CS rose.
  function automatic exec_e classify(state_e st, logic [7:0] op, logic ovl);
    case (st)
      ST_TX:   return EX_NONE;
      ST_WAIT: return ovl ? EX_ERR : EX_RUN;
      ST_ARG:  return (op == OP_ALL_OFF) ? EX_RUN : EX_ERR;
      default: return EX_ERR;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_frontend.sv
// Oversampling SPI mode-0 slave front end: synchronizers, edge detect,
// byte assembly on spi_clk rise and MISO shifting on spi_clk fall.
module spi_slave_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int TX_W        = 48
) (
  input  logic            clk_12mhz,
  input  logic            rst,
  input  logic            spi_clk_i,
  input  logic            spi_mosi_i,
  input  logic            spi_cs_i,
  output logic            spi_miso_o,
  input  logic            tx_load_i,
  input  logic [TX_W-1:0] tx_data_i,
  output logic            bit_valid_o,
  output logic            byte_valid_o,
  output logic [7:0]      byte_data_o,
  output logic            cs_fall_o,
  output logic            cs_rise_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             rx_sh_q;
  logic [TX_W-1:0]        tx_sh_q;
  logic                   miso_q, bit_valid_q, byte_valid_q;
  logic [7:0]             byte_data_q;

  logic sclk_s, mosi_s, cs_s, sclk_rise, sclk_fall;
  logic [7:0] rx_byte_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
  assign rx_byte_d = {rx_sh_q, mosi_s};

  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      // NOTE: the CS chain resets to "selected" so that a CS already low when
      // reset drops creates no fall; only a fresh high-to-low starts a frame.
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      cs_sync_q    <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b0;
      bit_cnt_q    <= '0;
      rx_sh_q      <= '0;
      tx_sh_q      <= '0;
      miso_q       <= 1'b0;
      bit_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
    end else begin
      // NOTE: non-blocking throughout so every stage sees last cycle's value.
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      bit_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= '0;
        tx_sh_q   <= '0;
        miso_q    <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_sh_q     <= rx_byte_d[6:0];
          bit_cnt_q   <= bit_cnt_q + 3'd1;
          bit_valid_q <= 1'b1;
          if (bit_cnt_q == 3'd7) begin
            byte_valid_q <= 1'b1;
            byte_data_q  <= rx_byte_d;
          end
        end
        // Zeros shift in behind the payload, so MISO idles low once drained.
        if (tx_load_i) begin
          tx_sh_q <= tx_data_i;
        end else if (sclk_fall) begin
          miso_q  <= tx_sh_q[TX_W-1];
          tx_sh_q <= tx_sh_q << 1;
        end
      end
    end
  end

  assign spi_miso_o   = miso_q;
  assign bit_valid_o  = bit_valid_q;
  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign cs_fall_o    = ~cs_s & cs_prev_q;
  assign cs_rise_o    = cs_s & ~cs_prev_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes 2-byte frames into analogue selects and
// device chip-selects, and serves a coherent counter snapshot on MISO.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 24,
  parameter int SEL_W         = 4,
  parameter int RELAY_RST_CYC = 12
) (
  input  logic             clk_12mhz,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  input  logic             spi_cs,
  output logic             spi_miso,
  input  logic [CNT_W-1:0] count_p,
  input  logic [CNT_W-1:0] count_m,
  output logic [SEL_W-1:0] input_sel,
  output logic [SEL_W-1:0] mu_sel,
  output logic [SEL_W-1:0] avk_sel,
  output logic             fil1_sel,
  output logic             fil2_sel,
  output logic             comp1_cs,
  output logic             comp2_cs,
  output logic             relay_cs,
  output logic             relay_reset,
  output logic             cmd_err
);

  localparam int TX_W  = 2 * CNT_W;
  localparam int RLY_W = $clog2(RELAY_RST_CYC + 1);

  logic            bit_valid, byte_valid, cs_fall, cs_rise, tx_load;
  logic [7:0]      byte_data;
  logic [TX_W-1:0] tx_data;

  state_e           state_q;
  exec_e            exec_q;
  logic [7:0]       op_q, arg_q;
  logic             ovl_q;
  logic [SEL_W-1:0] input_sel_q, mu_sel_q, avk_sel_q;
  logic             fil1_q, fil2_q, comp1_q, comp2_q, relay_cs_q;
  logic             relay_reset_q, cmd_err_q;
  logic [RLY_W-1:0] relay_cnt_q;

  // The shift register itself is the snapshot: both counters land in one cycle.
  assign tx_load = (state_q == ST_CMD) && byte_valid && (byte_data == OP_READ_CNT);
  assign tx_data = {count_p, count_m};

  spi_slave_frontend #(
    .SYNC_STAGES(SYNC_STAGES),
    .TX_W       (TX_W)
  ) u_frontend (
    .clk_12mhz   (clk_12mhz),
    .rst         (rst),
    .spi_clk_i   (spi_clk),
    .spi_mosi_i  (spi_mosi),
    .spi_cs_i    (spi_cs),
    .spi_miso_o  (spi_miso),
    .tx_load_i   (tx_load),
    .tx_data_i   (tx_data),
    .bit_valid_o (bit_valid),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise)
  );

  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      exec_q        <= EX_NONE;
      op_q          <= '0;
      arg_q         <= '0;
      ovl_q         <= 1'b0;
      input_sel_q   <= '0;
      mu_sel_q      <= '0;
      avk_sel_q     <= '0;
      fil1_q        <= 1'b0;
      fil2_q        <= 1'b0;
      comp1_q       <= 1'b1;
      comp2_q       <= 1'b1;
      relay_cs_q    <= 1'b1;
      relay_reset_q <= 1'b0;
      relay_cnt_q   <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      if (relay_cnt_q != '0) begin
        relay_cnt_q   <= relay_cnt_q - 1'b1;
        relay_reset_q <= (relay_cnt_q != RLY_W'(1));
      end
      if (cs_rise && state_q != ST_IDLE && state_q != ST_EXEC) begin
        exec_q  <= classify(state_q, op_q, ovl_q);
        state_q <= ST_EXEC;
      end else begin
        case (state_q)
          ST_IDLE: if (cs_fall) begin
            state_q <= ST_CMD;
            op_q    <= '0;
            arg_q   <= '0;
            ovl_q   <= 1'b0;
          end
          ST_CMD: if (byte_valid) begin
            op_q    <= byte_data;
            state_q <= (byte_data == OP_READ_CNT) ? ST_TX : ST_ARG;
          end
          ST_ARG: if (byte_valid) begin
            arg_q   <= byte_data;
            state_q <= ST_WAIT;
          end
          ST_WAIT: if (bit_valid) ovl_q <= 1'b1;
          ST_TX: ;
          ST_EXEC: begin
            state_q <= ST_IDLE;
            if (exec_q == EX_ERR) begin
              cmd_err_q <= 1'b1;
            end else if (exec_q == EX_RUN) begin
              case (op_q)
                OP_SET_SEL: begin
                  case (arg_q[7:4])
                    FLD_INPUT: input_sel_q <= SEL_W'(arg_q[3:0]);
                    FLD_MU:    mu_sel_q    <= SEL_W'(arg_q[3:0]);
                    FLD_AVK:   avk_sel_q   <= SEL_W'(arg_q[3:0]);
                    FLD_FIL1:  fil1_q      <= arg_q[0];
                    FLD_FIL2:  fil2_q      <= arg_q[0];
                    default:   cmd_err_q   <= 1'b1;
                  endcase
                end
                OP_NOP: cmd_err_q <= 1'b0;
                OP_DEV_SEL: begin
                  comp1_q    <= (arg_q != DEV_COMP1);
                  comp2_q    <= (arg_q != DEV_COMP2);
                  relay_cs_q <= (arg_q != DEV_RELAY);
                end
                OP_ALL_OFF: begin
                  input_sel_q   <= '0;
                  mu_sel_q      <= '0;
                  avk_sel_q     <= '0;
                  fil1_q        <= 1'b0;
                  fil2_q        <= 1'b0;
                  comp1_q       <= 1'b1;
                  comp2_q       <= 1'b1;
                  relay_cs_q    <= 1'b1;
                  relay_cnt_q   <= RLY_W'(RELAY_RST_CYC);
                  relay_reset_q <= 1'b1;
                end
                OP_READ_CNT: ;
                default: cmd_err_q <= 1'b1;
              endcase
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign input_sel   = input_sel_q;
  assign mu_sel      = mu_sel_q;
  assign avk_sel     = avk_sel_q;
  assign fil1_sel    = fil1_q;
  assign fil2_sel    = fil2_q;
  assign comp1_cs    = comp1_q;
  assign comp2_cs    = comp2_q;
  assign relay_cs    = relay_cs_q;
  assign relay_reset = relay_reset_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: a frame-level model predicts every output
// each cycle, and literal checks pin the model on the key scenarios.
module tb_spi_cmd_ctrl;

  localparam int S    = 2;
  localparam int HALF = 6;
  localparam int TCLK = 10;

  logic        clk = 1'b0;
  logic        rst, spi_clk, spi_mosi, spi_cs;
  logic        spi_miso;
  logic [23:0] count_p, count_m;
  logic [3:0]  input_sel, mu_sel, avk_sel;
  logic        fil1_sel, fil2_sel, comp1_cs, comp2_cs, relay_cs, relay_reset, cmd_err;

  spi_cmd_ctrl #(
    .SYNC_STAGES  (S),
    .CNT_W        (24),
    .SEL_W        (4),
    .RELAY_RST_CYC(12)
  ) dut (
    .clk_12mhz  (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_cs     (spi_cs),
    .spi_miso   (spi_miso),
    .count_p    (count_p),
    .count_m    (count_m),
    .input_sel  (input_sel),
    .mu_sel     (mu_sel),
    .avk_sel    (avk_sel),
    .fil1_sel   (fil1_sel),
    .fil2_sel   (fil2_sel),
    .comp1_cs   (comp1_cs),
    .comp2_cs   (comp2_cs),
    .relay_cs   (relay_cs),
    .relay_reset(relay_reset),
    .cmd_err    (cmd_err)
  );

  always #(TCLK / 2) clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [3:0] exp_input, exp_mu, exp_avk;
  logic       exp_fil1, exp_fil2, exp_comp1, exp_comp2, exp_relay_cs, exp_err;
  time        relay_t0;
  bit         relay_armed;
  logic [63:0] rx_bits;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_input = 4'h0; exp_mu = 4'h0; exp_avk = 4'h0;
    exp_fil1 = 1'b0; exp_fil2 = 1'b0;
    exp_comp1 = 1'b1; exp_comp2 = 1'b1; exp_relay_cs = 1'b1;
    exp_err = 1'b0;
    relay_armed = 1'b0;
  endtask

  // Frame rules applied to the whole bit string at commit time.
  task automatic model_frame(input logic [63:0] d, input int n);
    logic [7:0] op, arg;
    if (n < 8) begin
      exp_err = 1'b1;
      return;
    end
    op = 8'(d >> (n - 8));
    if (op == 8'h05) return;
    if (n > 16 || (n < 16 && op != 8'h04)) begin
      exp_err = 1'b1;
      return;
    end
    arg = (n == 16) ? d[7:0] : 8'h00;
    case (op)
      8'h01: case (arg[7:4])
        4'd1: exp_input = arg[3:0];
        4'd2: exp_mu = arg[3:0];
        4'd3: exp_avk = arg[3:0];
        4'd4: exp_fil1 = arg[0];
        4'd5: exp_fil2 = arg[0];
        default: exp_err = 1'b1;
      endcase
      8'h02: exp_err = 1'b0;
      8'h03: begin
        exp_comp1 = (arg != 8'd1);
        exp_comp2 = (arg != 8'd2);
        exp_relay_cs = (arg != 8'd3);
      end
      8'h04: begin
        exp_input = 4'h0; exp_mu = 4'h0; exp_avk = 4'h0;
        exp_fil1 = 1'b0; exp_fil2 = 1'b0;
        exp_comp1 = 1'b1; exp_comp2 = 1'b1; exp_relay_cs = 1'b1;
        relay_t0 = $time;
        relay_armed = 1'b1;
      end
      default: exp_err = 1'b1;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("input_sel", {60'd0, input_sel}, {60'd0, exp_input});
      check("mu_sel", {60'd0, mu_sel}, {60'd0, exp_mu});
      check("avk_sel", {60'd0, avk_sel}, {60'd0, exp_avk});
      check("fil1_sel", {63'd0, fil1_sel}, {63'd0, exp_fil1});
      check("fil2_sel", {63'd0, fil2_sel}, {63'd0, exp_fil2});
      check("comp1_cs", {63'd0, comp1_cs}, {63'd0, exp_comp1});
      check("comp2_cs", {63'd0, comp2_cs}, {63'd0, exp_comp2});
      check("relay_cs", {63'd0, relay_cs}, {63'd0, exp_relay_cs});
      check("cmd_err", {63'd0, cmd_err}, {63'd0, exp_err});
      check("relay_reset", {63'd0, relay_reset},
            {63'd0, relay_armed && ($time > relay_t0) && ($time < relay_t0 + 12 * TCLK)});
    end
  end

  task automatic frame_begin();
    @(posedge clk); #1;
    spi_cs = 1'b0;
    repeat (HALF) @(posedge clk); #1;
  endtask

  task automatic spi_bits(input logic [63:0] d, input int n);
    rx_bits = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = d[i];
      repeat (HALF) @(posedge clk); #1;
      rx_bits = {rx_bits[62:0], spi_miso};
      spi_clk = 1'b1;
      repeat (HALF) @(posedge clk); #1;
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_end(input logic [63:0] d, input int n, input bit apply);
    repeat (HALF) @(posedge clk); #1;
    spi_cs = 1'b1;
    if (apply) begin
      repeat (S + 2) @(posedge clk);
      model_frame(d, n);
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic send(input logic [63:0] d, input int n);
    frame_begin();
    spi_bits(d, n);
    frame_end(d, n, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    #(TCLK * 100000);
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, cnt;
    rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1;
    count_p = '0; count_m = '0;
    model_reset();
    repeat (4) @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;

    check("rst input_sel", {60'd0, input_sel}, 64'h0);
    check("rst comp1/comp2/relay_cs", {61'd0, comp1_cs, comp2_cs, relay_cs}, 64'h7);
    check("rst relay_reset/cmd_err/miso", {61'd0, relay_reset, cmd_err, spi_miso}, 64'h0);
    chk_en = 1'b1;

    // SET_SEL: avk field and fil2 field
    send(64'h0133, 16);
    send(64'h0151, 16);
    check("avk_sel after 0133", {60'd0, avk_sel}, 64'h3);
    check("fil2_sel after 0151", {63'd0, fil2_sel}, 64'h1);
    check("input/mu untouched", {56'd0, input_sel, mu_sel}, 64'h0);
    check("cmd_err clean", {63'd0, cmd_err}, 64'h0);
    send(64'h012A, 16);
    send(64'h0141, 16);
    check("mu_sel after 012A", {60'd0, mu_sel}, 64'hA);

    // DEV_SEL one-hot behaviour
    send(64'h0302, 16);
    check("dev 2", {61'd0, comp1_cs, comp2_cs, relay_cs}, 64'h5);
    send(64'h0303, 16);
    check("dev 3", {61'd0, comp1_cs, comp2_cs, relay_cs}, 64'h6);
    send(64'h030F, 16);
    check("dev other", {61'd0, comp1_cs, comp2_cs, relay_cs}, 64'h7);
    send(64'h0301, 16);

    // 8-bit ALL_OFF: pulse position and length measured from the CS pin
    frame_begin();
    spi_bits(64'h04, 8);
    first = -1;
    cnt = 0;
    fork
      frame_end(64'h04, 8, 1'b1);
      begin
        @(posedge spi_cs);
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (relay_reset === 1'b1) begin
            if (first < 0) first = k;
            cnt++;
          end
        end
      end
    join
    check("relay_reset start", 64'(first), 64'd4);
    check("relay_reset length", 64'(cnt), 64'd12);
    check("all_off selects", {48'd0, input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel,
          comp1_cs, comp2_cs}, 64'h3);
    send(64'h0400, 16);

    // Counter read-back; counters move mid-frame
    count_p = 24'hA5A5A5;
    count_m = 24'h123456;
    frame_begin();
    fork
      spi_bits(64'h05 << 48, 56);
      begin
        repeat (300) @(posedge clk); #1;
        count_p = 24'h000FFF;
        count_m = 24'hABCDEF;
      end
    join
    check("miso readback", rx_bits, 64'h00A5A5A5123456);
    repeat (HALF) @(posedge clk); #1;
    check("miso after 48 bits", {63'd0, spi_miso}, 64'h0);
    frame_end(64'h05 << 48, 56, 1'b1);

    // Short, unknown and overlength frames
    send(64'h0035, 13);
    check("short frame err", {63'd0, cmd_err}, 64'h1);
    check("short frame no change", {60'd0, input_sel}, 64'h0);
    send(64'h0700, 16);
    check("bad opcode err", {63'd0, cmd_err}, 64'h1);
    send(64'h0200, 16);
    check("nop clears err", {63'd0, cmd_err}, 64'h0);
    send(64'h0301 << 3 | 64'h5, 19);
    check("overlength err", {63'd0, cmd_err}, 64'h1);
    check("overlength no change", {63'd0, comp1_cs}, 64'h1);
    send(64'h0163, 16);
    check("bad field no change", {60'd0, avk_sel}, 64'h0);
    send(64'h0200, 16);

    // Reset in the middle of a frame
    send(64'h0133, 16);
    frame_begin();
    spi_bits(64'h011F >> 6, 10);
    do_reset();
    spi_bits(64'h011F & 64'h3F, 6);
    frame_end(64'h0, 0, 1'b0);
    check("mid-frame rst input_sel", {60'd0, input_sel}, 64'h0);
    check("mid-frame rst cmd_err", {63'd0, cmd_err}, 64'h0);
    send(64'h011F, 16);
    check("after rst full frame", {60'd0, input_sel}, 64'hF);
    check("miso idle with cs high", {63'd0, spi_miso}, 64'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
